load_store_unit: RTL and testbench

Sits between the execute stage and the word-addressed `DataMemory` and turns RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. It converts byte addresses to word indices and enforces natural alignment. Loads get byte/halfword extraction with sign or zero extension. Byte and halfword stores are performed as read-modify-write sequences, because the memory has no byte enables. The block is a single-outstanding-request FSM with a valid/ready request port and a one-cycle `Done` response.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pkg                                                                |
// | Shared RISC-V load/store definitions: funct3 size/sign codes, the LSU    |
// | state encoding and small decode helpers used by the load/store unit.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_RD   = 3'd1,
    LSU_WAIT = 3'd2,
    LSU_WR   = 3'd3,
    LSU_DONE = 3'd4
  } lsu_state_t;

  // Stores have no unsigned variants, so only B/H/W are accepted for them.
  function automatic logic f3_is_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return (lane != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_lane_align                                                           |
// | Combinational byte-lane steering for the load/store unit.                |
// |   word        : word read from memory                                    |
// |   offset      : byte offset of the access inside the word                |
// |   funct3      : RISC-V size/sign code                                    |
// |   store_data  : store operand (low byte/halfword used for SB/SH)         |
// |   load_value  : extracted and sign/zero-extended load result             |
// |   merged_word : read word with the store lane(s) replaced                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_lane_align
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32  // four byte lanes assumed
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];

    load_value = word;
    case (funct3)
      F3_B:    load_value = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      F3_H:    load_value = {{(WIDTH-16){sel_half[15]}}, sel_half};
      F3_BU:   load_value = {{(WIDTH-8){1'b0}}, sel_byte};
      F3_HU:   load_value = {{(WIDTH-16){1'b0}}, sel_half};
      default: load_value = word;
    endcase

    merged_word = store_data;
    case (funct3)
      F3_B: begin
        merged_word = word;
        merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      end
      F3_H: begin
        merged_word = word;
        merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit                                                          |
// | Single-outstanding RISC-V load/store unit in front of a word-addressed   |
// | memory without byte enables. SB/SH are done as read-modify-write.        |
// |   clk, rst            : clock, synchronous active-high reset             |
// |   ReqValid/ReqReady   : request handshake (ready only when idle)         |
// |   ReqWrite, Funct3    : store flag and RISC-V size/sign code             |
// |   ReqAddr, ReqWData   : byte address and store data                      |
// |   Done                : one-cycle completion pulse                       |
// |   LoadData            : extended load result, held until next load       |
// |   Misaligned, Illegal : fault flags, valid with Done                     |
// |   MemRead/MemWrite    : memory strobes                                   |
// |   MemAddr, MemWData   : word index and write data (0 when no strobe)     |
// |   MemRData            : read data, valid the cycle after MemRead         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int Width       = 32,  // only 32 is supported
  parameter int MemAddrBits = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [2:0]             Funct3,
  input  logic [Width-1:0]       ReqAddr,
  input  logic [Width-1:0]       ReqWData,
  output logic                   Done,
  output logic [Width-1:0]       LoadData,
  output logic                   Misaligned,
  output logic                   Illegal,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic [MemAddrBits-1:0] MemAddr,
  output logic [Width-1:0]       MemWData,
  input  logic [Width-1:0]       MemRData
);

  lsu_state_t state, state_next;

  logic                   req_write;
  logic [2:0]             req_f3;
  logic [1:0]             req_lane;
  logic [MemAddrBits-1:0] req_idx;
  logic [Width-1:0]       req_wdata;
  logic [Width-1:0]       merged_q;
  logic [Width-1:0]       load_q;
  logic                   misaligned_q;
  logic                   illegal_q;

  logic                   accept;
  logic                   req_legal;
  logic                   req_misaligned;
  logic [Width-1:0]       lane_load;
  logic [Width-1:0]       lane_merged;

  // Address bits above the word index are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^ReqAddr[Width-1:MemAddrBits+2];

  assign accept         = ReqValid && (state == LSU_IDLE);
  assign req_legal      = f3_is_legal(ReqWrite, Funct3);
  assign req_misaligned = is_misaligned(Funct3, ReqAddr[1:0]);

  lsu_lane_align #(.WIDTH(Width)) u_lane_align (
    .word        (MemRData),
    .offset      (req_lane),
    .funct3      (req_f3),
    .store_data  (req_wdata),
    .load_value  (lane_load),
    .merged_word (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LSU_IDLE;
      req_write    <= 1'b0;
      req_f3       <= 3'b000;
      req_lane     <= 2'b00;
      req_idx      <= '0;
      req_wdata    <= '0;
      merged_q     <= '0;
      load_q       <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_write    <= ReqWrite;
        req_f3       <= Funct3;
        req_lane     <= ReqAddr[1:0];
        req_idx      <= ReqAddr[MemAddrBits+1:2];
        req_wdata    <= ReqWData;
        // Illegal wins: a misaligned flag is only raised on a legal funct3.
        illegal_q    <= !req_legal;
        misaligned_q <= req_legal && req_misaligned;
      end
      if (state == LSU_WAIT) begin
        if (req_write) merged_q <= lane_merged;
        else           load_q   <= lane_load;
      end
    end
  end

  always_comb begin
    state_next = state;
    ReqReady   = 1'b0;
    Done       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    case (state)
      LSU_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (!req_legal || req_misaligned) state_next = LSU_DONE;
          else if (ReqWrite && (Funct3 == F3_W)) state_next = LSU_WR;
          else state_next = LSU_RD;  // loads and SB/SH both read first
        end
      end
      LSU_RD: begin
        MemRead    = 1'b1;
        MemAddr    = req_idx;
        state_next = LSU_WAIT;
      end
      LSU_WAIT: state_next = req_write ? LSU_WR : LSU_DONE;
      LSU_WR: begin
        MemWrite   = 1'b1;
        MemAddr    = req_idx;
        MemWData   = (req_f3 == F3_W) ? req_wdata : merged_q;
        state_next = LSU_DONE;
      end
      LSU_DONE: begin
        Done       = 1'b1;
        state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  assign LoadData   = load_q;
  assign Misaligned = Done && misaligned_q;
  assign Illegal    = Done && illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_store_unit                                                       |
// | Self-checking bench: directed scenarios plus random requests against a   |
// | byte-arithmetic reference model and a behavioural word memory.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [2:0]  Funct3;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        Done;
  logic [31:0] LoadData;
  logic        Misaligned;
  logic        Illegal;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;

  always #5 clk = ~clk;

  load_store_unit #(.Width(32), .MemAddrBits(9)) dut (
    .clk(clk), .rst(rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .Funct3(Funct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .Done(Done), .LoadData(LoadData), .Misaligned(Misaligned), .Illegal(Illegal),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData)
  );

  // Word-addressed data memory with one-cycle read latency.
  logic [31:0] mem [512];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
    end else begin
      if (MemWrite) mem[MemAddr] <= MemWData;
      if (MemRead)  MemRData <= mem[MemAddr];
    end
  end

  logic [31:0] ref_mem [512];
  logic [31:0] exp_ld;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: model the expected outcome, drive it, observe every cycle.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int f, lane, size, lat, exp_rd, exp_wr, exp_rd_cyc, exp_wr_cyc, idx;
    logic legal, mis;
    logic [31:0] old, nw, v, mask;
    int rd_n, wr_n, rd_cyc, wr_cyc, bad, done_cyc;
    logic [31:0] wdata_seen;

    f    = int'(f3);
    lane = int'(a[1:0]);
    idx  = int'((a >> 2) % 512);
    size = f % 4;
    legal = w ? (f <= 2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
    mis   = legal && ((size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0));
    old = ref_mem[idx];
    nw  = old;
    exp_rd = 0; exp_wr = 0; exp_rd_cyc = 0; exp_wr_cyc = 0;
    if (!legal || mis) begin
      lat = 1;
    end else if (!w) begin
      lat = 3; exp_rd = 1; exp_rd_cyc = 1;
      if (size == 0) begin
        v = (old >> (8 * lane)) & 32'hFF;
        if (f == 0 && v >= 128) v = v | 32'hFFFFFF00;
      end else if (size == 1) begin
        v = (old >> (8 * lane)) & 32'hFFFF;
        if (f == 1 && v >= 32768) v = v | 32'hFFFF0000;
      end else begin
        v = old;
      end
      exp_ld = v;
    end else if (size == 2) begin
      lat = 2; exp_wr = 1; exp_wr_cyc = 1; nw = d;
    end else begin
      lat = 4; exp_rd = 1; exp_wr = 1; exp_rd_cyc = 1; exp_wr_cyc = 3;
      mask = ((size == 0) ? 32'hFF : 32'hFFFF) << (8 * lane);
      nw = (old & ~mask) | ((d << (8 * lane)) & mask);
    end
    ref_mem[idx] = nw;

    @(negedge clk);
    check({tag, ":ready"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = w; Funct3 = f3; ReqAddr = a; ReqWData = d;
    @(posedge clk);
    rd_n = 0; wr_n = 0; rd_cyc = 0; wr_cyc = 0; bad = 0; done_cyc = 0;
    wdata_seen = 32'h0;
    for (int n = 1; n <= 8 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Garbage on the request bus while busy must be ignored.
        ReqValid = 1'b0; ReqWrite = 1'($urandom); Funct3 = 3'($urandom);
        ReqAddr = $urandom; ReqWData = $urandom;
      end
      if (MemRead) begin
        rd_n++; rd_cyc = n;
        if (int'(MemAddr) != idx) bad++;
      end
      if (MemWrite) begin
        wr_n++; wr_cyc = n; wdata_seen = MemWData;
        if (int'(MemAddr) != idx) bad++;
      end
      if (!MemRead && !MemWrite && (MemAddr != 9'd0 || MemWData != 32'd0)) bad++;
      if (ReqReady) bad++;
      if (!Done && (Misaligned || Illegal)) bad++;
      if (Done) begin
        done_cyc = n;
        check({tag, ":misaligned"}, 32'(Misaligned), 32'(mis));
        check({tag, ":illegal"}, 32'(Illegal), 32'(!legal));
        check({tag, ":loaddata"}, LoadData, exp_ld);
      end
    end
    check({tag, ":latency"}, 32'(done_cyc), 32'(lat));
    check({tag, ":reads"}, 32'(rd_n), 32'(exp_rd));
    check({tag, ":writes"}, 32'(wr_n), 32'(exp_wr));
    check({tag, ":rd_cycle"}, 32'(rd_cyc), 32'(exp_rd_cyc));
    check({tag, ":wr_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
    if (exp_wr != 0) check({tag, ":wdata"}, wdata_seen, nw);
    check({tag, ":strobe_rules"}, 32'(bad), 32'd0);
    check({tag, ":mem_word"}, mem[idx], nw);
  endtask

  initial begin
    int wr_seen, done_seen;
    rst = 1'b1; mem_init = 1'b1;
    ReqValid = 1'b0; ReqWrite = 1'b0; Funct3 = 3'b000; ReqAddr = 32'h0; ReqWData = 32'h0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    ref_mem[5] = 32'h8899AABB;
    exp_ld = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:ready", 32'(ReqReady), 32'd1);
    check("rst:done", 32'(Done), 32'd0);
    check("rst:faults", 32'({Misaligned, Illegal}), 32'd0);
    check("rst:strobes", 32'({MemRead, MemWrite}), 32'd0);
    check("rst:loaddata", LoadData, 32'h0);
    check("rst:memaddr", 32'(MemAddr), 32'd0);
    check("rst:memwdata", MemWData, 32'h0);
    rst = 1'b0; mem_init = 1'b0;

    run_op(1'b0, 3'b000, 32'h15, 32'h0, "lb");
    check("lb:const", LoadData, 32'hFFFFFFAA);
    run_op(1'b0, 3'b100, 32'h15, 32'h0, "lbu");
    check("lbu:const", LoadData, 32'h000000AA);
    run_op(1'b0, 3'b001, 32'h16, 32'h0, "lh");
    check("lh:const", LoadData, 32'hFFFF8899);
    run_op(1'b0, 3'b010, 32'h14, 32'h0, "lw");
    check("lw:const", LoadData, 32'h8899AABB);
    run_op(1'b1, 3'b001, 32'h16, 32'hDEAD1234, "sh");
    check("sh:const_mem", mem[5], 32'h1234AABB);
    run_op(1'b0, 3'b010, 32'h14, 32'h0, "lw_after_sh");
    check("lw_after_sh:const", LoadData, 32'h1234AABB);
    run_op(1'b1, 3'b010, 32'h13, 32'h55555555, "sw_misaligned");
    run_op(1'b0, 3'b011, 32'h14, 32'h0, "ld_illegal");
    run_op(1'b1, 3'b011, 32'h15, 32'h0, "st_illegal_over_mis");
    run_op(1'b1, 3'b010, 32'h20, 32'h00000042, "sw_b2b");
    run_op(1'b0, 3'b010, 32'h20, 32'h0, "lw_b2b");
    check("lw_b2b:const", LoadData, 32'h00000042);
    run_op(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, "sw_hold");
    check("sw_hold:const", LoadData, 32'h00000042);
    run_op(1'b0, 3'b010, 32'h8000_0814, 32'h0, "lw_wrap");

    // Reset while an SB sits in WAIT: the write must never be issued.
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = 3'b000; ReqAddr = 32'h15; ReqWData = 32'h77;
    @(posedge clk);
    @(negedge clk);
    ReqValid = 1'b0;
    check("rstwait:rd", 32'(MemRead), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ld = 32'h0;
    check("rstwait:ready", 32'(ReqReady), 32'd1);
    check("rstwait:loaddata", LoadData, exp_ld);
    wr_seen = 0; done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (MemWrite) wr_seen++;
      if (Done) done_seen++;
    end
    check("rstwait:no_write", 32'(wr_seen), 32'd0);
    check("rstwait:no_done", 32'(done_seen), 32'd0);
    check("rstwait:mem5", mem[5], ref_mem[5]);

    // Reset together with a valid request: nothing is accepted.
    @(negedge clk);
    rst = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b0; Funct3 = 3'b010; ReqAddr = 32'h14;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ReqValid = 1'b0;
    check("rstvalid:ready", 32'(ReqReady), 32'd1);
    check("rstvalid:no_read", 32'(MemRead), 32'd0);

    for (int k = 0; k < 80; k++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 31)), $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
